// File: rtl/t_phase_mul4.sv
// Phase-sequenced 4x4 unsigned shift-add multiplier driven by an 8-phase one-hot
// timing ring; one job per ring rotation, with a sticky phase-sequence checker.
module t_phase_mul4 (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:7] T,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     r_state, w_state_n;
  logic [7:0] r_p, w_p_n;
  logic [3:0] r_a, w_a_n;
  logic [3:0] r_b, w_b_n;
  logic [2:0] r_e, w_e_n;
  logic       r_pending, w_pending_n;
  logic [7:0] w_product_n;
  logic       w_busy_n, w_done_n, w_err_n;

  logic       w_phase0;
  logic [0:7] w_exp_t;
  logic [1:0] w_bidx;
  logic       w_in_mul;
  logic [7:0] w_addend;

  assign w_phase0 = (T == 8'h80);
  assign w_exp_t  = 8'h80 >> r_e;
  // E=1..4 selects multiplier bit 0..3 and the matching shift of A
  assign w_bidx   = r_e[1:0] - 2'd1;
  assign w_in_mul = (r_e >= 3'd1) && (r_e <= 3'd4);
  assign w_addend = {4'b0000, r_a} << w_bidx;

  always_comb begin
    w_state_n   = r_state;
    w_p_n       = r_p;
    w_a_n       = r_a;
    w_b_n       = r_b;
    w_e_n       = r_e;
    w_pending_n = r_pending;
    w_product_n = product;
    w_busy_n    = busy;
    w_done_n    = 1'b0;
    w_err_n     = err;
    case (r_state)
      IDLE: begin
        if ((start || r_pending) && w_phase0) begin
          w_a_n       = a;
          w_b_n       = b;
          w_p_n       = '0;
          w_pending_n = 1'b0;
          w_busy_n    = 1'b1;
          w_e_n       = 3'd1;
          w_state_n   = RUN;
        end else if (start) begin
          w_pending_n = 1'b1;
        end
      end
      RUN: begin
        if (T != w_exp_t) begin
          w_err_n     = 1'b1;
          w_busy_n    = 1'b0;
          w_pending_n = 1'b0;
          w_state_n   = IDLE;
        end else begin
          w_e_n = r_e + 3'd1;
          if (start) w_pending_n = 1'b1;
          if (w_in_mul && r_b[w_bidx]) w_p_n = r_p + w_addend;
          if (r_e == 3'd5) begin
            w_product_n = r_p;
            w_done_n    = 1'b1;
            w_busy_n    = 1'b0;
            w_state_n   = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_p       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_e       <= '0;
      r_pending <= 1'b0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_p       <= w_p_n;
      r_a       <= w_a_n;
      r_b       <= w_b_n;
      r_e       <= w_e_n;
      r_pending <= w_pending_n;
      product   <= w_product_n;
      busy      <= w_busy_n;
      done      <= w_done_n;
      err       <= w_err_n;
    end
  end

endmodule

// File: tb/tb_t_phase_mul4.sv
// Scoreboard bench for t_phase_mul4: stimulus pushes expected products, a negedge
// monitor pops and checks them (and the phase they appear in) on every done pulse.
module tb_t_phase_mul4;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:7] T;
  logic       start;
  logic [3:0] a, b;
  logic [7:0] product;
  logic       busy, done, err;

  int         checks = 0;
  int         errors = 0;
  int         ph = 0;
  logic       corrupt = 1'b0;
  logic [7:0] exp_q[$];

  t_phase_mul4 dut (
    .clock  (clk),
    .reset  (reset),
    .T      (T),
    .start  (start),
    .a      (a),
    .b      (b),
    .product(product),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock of the ring: T advances to the next phase just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 8;
    T  = corrupt ? 8'h00 : (8'h80 >> ph);
  endtask

  task automatic goto_phase(input int k);
    int n = 0;
    while (ph != k && n < 16) begin
      tick();
      n++;
    end
    if (ph != k) begin
      checks++;
      errors++;
      $display("FAIL goto_phase actual=%0d required=%0d", ph, k);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0d required=none phase=%0d", product, ph);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("done_product", product, e);
        chk("done_phase", 8'(ph), 8'd6);
      end
    end
  end

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b1; a = 4'd0; b = 4'd0;
    ph = 0; T = 8'h80;

    // reset dominates a held start while the ring runs
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_product", product, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_err", {7'd0, err}, 8'd0);
    end
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_no_launch", {7'd0, busy}, 8'd0);
    end

    // basic 13*11
    goto_phase(0);
    a = 4'd13; b = 4'd11; start = 1'b1;
    exp_q.push_back(8'd143);
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b1) break;
      cnt++;
      tick();
    end
    chk("busy_cycles", 8'(cnt), 8'd5);
    chk("basic_err", {7'd0, err}, 8'd0);

    // pending launch from a start at phase 3
    goto_phase(3);
    a = 4'd15; b = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(8'd225);
    while (ph != 0) begin
      chk("pending_wait_busy", {7'd0, busy}, 8'd0);
      tick();
    end
    tick();
    chk("pending_launch_busy", {7'd0, busy}, 8'd1);
    goto_phase(7);

    // back-to-back jobs with start held high
    goto_phase(0);
    a = 4'd3; b = 4'd5; start = 1'b1;
    exp_q.push_back(8'd15);
    tick();
    goto_phase(0);
    a = 4'd0; b = 4'd9;
    exp_q.push_back(8'd0);
    tick();
    start = 1'b0;
    goto_phase(7);

    // reference job then a corrupted phase 2
    goto_phase(0);
    a = 4'd6; b = 4'd7; start = 1'b1;
    exp_q.push_back(8'd42);
    tick();
    start = 1'b0;
    goto_phase(7);
    goto_phase(0);
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    tick();
    chk("corrupt_err", {7'd0, err}, 8'd1);
    chk("corrupt_busy", {7'd0, busy}, 8'd0);
    chk("corrupt_product", product, 8'd42);
    goto_phase(7);
    goto_phase(0);
    a = 4'd2; b = 4'd7; start = 1'b1;
    exp_q.push_back(8'd14);
    tick();
    start = 1'b0;
    goto_phase(7);
    chk("err_sticky", {7'd0, err}, 8'd1);
    chk("after_err_product", product, 8'd14);

    // reset while a job is at phase 3
    goto_phase(0);
    a = 4'd4; b = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    goto_phase(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_product", product, 8'd0);
    chk("midrst_done", {7'd0, done}, 8'd0);
    chk("midrst_err", {7'd0, err}, 8'd0);
    goto_phase(7);
    goto_phase(0);
    a = 4'd7; b = 4'd6; start = 1'b1;
    exp_q.push_back(8'd42);
    tick();
    start = 1'b0;
    goto_phase(7);
    tick();
    tick();

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_phase_mul4.md
# t_phase_mul4

Downstream consumer of the 8-phase one-hot timing generator (4-bit Johnson ring decoded to T[0:7]). It runs a 4×4 unsigned shift-add multiply that is sequenced by the timing phases, one multiplier bit per phase. It also checks that the incoming phase sequence stays legal while a job is running. A complete job occupies exactly one rotation of the ring.

## Interface
- No parameters; widths are fixed (4-bit operands, 8-bit product, 8 phases).
- clock  input  1  rising-edge system clock; same clock as the timing generator.
- reset  input  1  synchronous, active-high reset.
- T  input  [0:7]  one-hot phase from the timing generator. T[0] is the leftmost bit: phase 0 = 8'b10000000, phase 7 = 8'b00000001. The value changes once per clock.
- start  input  1  request a multiply; level or single-cycle pulse.
- a  input  4  multiplicand; sampled at the launch edge.
- b  input  4  multiplier; sampled at the launch edge.
- product  output  8  registered result; holds its value until the next job completes.
- busy  output  1  high while a job is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky phase-sequence error flag.

## Operation
- Phase k means T equals the one-hot value with bit T[k] set. Every decision is made on the T value sampled at the rising edge.
- The state machine has two states, IDLE and RUN. Internal state:
  - 8-bit accumulator P
  - captured operands A, B
  - 3-bit expected-phase register E
  - pending flag
- **IDLE**
  - start=1 with T≠phase 0 sets pending.
  - start=1 or pending=1, with T=phase 0, launches the job:
    - A<=a, B<=b, P<=0
    - pending<=0, busy<=1, E<=1
    - state<=RUN
  - start and phase 0 on the same edge launch directly; pending is not set.
- **RUN**, phase check on each edge:
  - T must equal phase E.
  - A match advances E.
  - Any mismatch aborts the job:
    - T=0, more than one bit set, a skipped phase, or a repeated phase all count as mismatches.
    - Abort action: err<=1, busy<=0, pending<=0, state<=IDLE.
    - product is unchanged and done is not pulsed.
- **RUN**, datapath:
  - At phases 1..4 (k=1..4): if B[k-1]=1 then P <= P + ({4'b0,A} << (k-1)).
  - 8-bit arithmetic cannot overflow (max 15×15=225).
  - At phase 5: product<=P, done<=1, busy<=0, state<=IDLE.
- start while in RUN sets pending. The next job launches at the next phase 0, giving back-to-back jobs every 8 clocks. a and b must be valid at that launch edge.
- done is cleared on the edge after it is set.
- err is cleared only by reset. The block keeps accepting jobs while err=1.
- Phases 6 and 7 are not checked; the check applies only in RUN.

## Timing
- **Reset** wins over every other input. It sets:
  - product=8'h00, busy=0, done=0, err=0
  - pending=0, P=0, E=0, state=IDLE
- **Launch** occurs at the edge sampling phase 0; busy is high from the next cycle.
- **Latency:** product is valid and done is high in the cycle following the edge that samples phase 5. That is 5 clocks after launch, while T shows phase 6.
- busy is high for exactly 5 cycles per job.
- **Throughput:** one job per 8 clocks.
- **Reset mid-RUN:** the job is discarded with no done pulse and product=0.
- A start that arrives in the same edge as the phase-5 sample sets pending, and the next job launches at the following phase 0.

## Test plan
- **Reset values:** hold reset 2 cycles with start=1 and T cycling. Expect product=0, busy=done=err=0 throughout, and no launch after release until start is seen.
- **Basic multiply:** a=13, b=11, start pulsed on the phase-0 edge. Expect:
  - busy high for 5 cycles
  - product=8'd143 with done=1 for one cycle while T=phase 6
  - err=0
- **Pending launch:** start pulsed while T=phase 3, with a=15, b=15 held. Expect no launch until the next phase 0, then product=8'd225 with done 5 clocks after that launch.
- **Back-to-back jobs:** start held high across phase 0 of two rotations with (3,5) then (0,9). Expect done pulses 8 clocks apart, with product=15 then product=0.
- **Corrupt phase:** force T=8'h00 in place of phase 2 during RUN. Expect err=1 next cycle, busy=0, no done, and product keeping its prior value. A later job with a=2, b=7 must still return 14 while err stays 1.
- **Reset mid-job:** assert reset for one cycle at phase 3 of a job. Expect busy=0, product=0, no done, and correct operation on the next start.
